// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel-word handshake plus serial output bundle.
// par_in/par_valid/par_ready in; data_out/out_valid/frame_start out (slave = serializer).
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_in;
  logic             par_valid;
  logic             par_ready;
  logic             data_out;
  logic             out_valid;
  logic             frame_start;

  modport master (
    output par_in,
    output par_valid,
    input  par_ready,
    input  data_out,
    input  out_valid,
    input  frame_start
  );

  modport slave (
    input  par_in,
    input  par_valid,
    output par_ready,
    output data_out,
    output out_valid,
    output frame_start
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter, 1-cycle latency, gapless frames.
// Ports: clk, rst (sync, active-high), bus (slave modport). Macro PISO_SERIALIZER_PARITY_EN adds even parity bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
  localparam logic [CW-1:0] LAST_D = CW'(WIDTH - 1);
`else
  localparam int FLEN = WIDTH;
`endif

  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_data_out;
  logic             w_data_nxt;
  logic             r_out_valid;
  logic             w_valid_nxt;
  logic             r_frame_start;
  logic             w_fs_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  // Next bit to emit and the word left after removing it.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0}
                            : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_ready  = (r_state == IDLE) || w_last;
  assign w_accept = bus.par_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_out;
    w_valid_nxt = r_out_valid;
    w_fs_nxt    = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_accept) begin
      // First bit goes straight to the output register.
      w_state_nxt = SHIFT;
      w_shreg_nxt = tail(bus.par_in);
      w_cnt_nxt   = '0;
      w_data_nxt  = head(bus.par_in);
      w_valid_nxt = 1'b1;
      w_fs_nxt    = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      w_par_nxt   = ^bus.par_in;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          w_data_nxt  = 1'b0;
          w_valid_nxt = 1'b0;
        end
        SHIFT: begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_data_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            if (r_cnt == LAST_D) begin
              w_data_nxt = r_par;
            end else begin
              w_data_nxt  = head(r_shreg);
              w_shreg_nxt = tail(r_shreg);
            end
`else
            w_data_nxt  = head(r_shreg);
            w_shreg_nxt = tail(r_shreg);
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_cnt         <= '0;
      r_data_out    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par         <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_cnt         <= w_cnt_nxt;
      r_data_out    <= w_data_nxt;
      r_out_valid   <= w_valid_nxt;
      r_frame_start <= w_fs_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par         <= w_par_nxt;
`endif
    end
  end

  assign bus.par_ready   = w_ready;
  assign bus.data_out    = r_data_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for LSB-first and MSB-first serializers.
// Expected serial patterns are hand-computed; bit k of exp is the k-th emitted bit.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) ifa ();
  piso_serializer_if #(.WIDTH(8)) ifb ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic v, input logic [7:0] d);
    if (m == 0) begin
      ifa.par_valid = v;
      ifa.par_in    = d;
    end else begin
      ifb.par_valid = v;
      ifb.par_in    = d;
    end
  endtask

  // {data_out, out_valid, frame_start, par_ready}
  function automatic logic [3:0] obs(input int m);
    if (m == 0)
      return {ifa.data_out, ifa.out_valid, ifa.frame_start, ifa.par_ready};
    return {ifb.data_out, ifb.out_valid, ifb.frame_start, ifb.par_ready};
  endfunction

  task automatic idle_chk(input string tag, input int m);
    logic [3:0] o;
    o = obs(m);
    check({tag, " dout"}, 32'(o[3]), 32'd0);
    check({tag, " ov"}, 32'(o[2]), 32'd0);
    check({tag, " fs"}, 32'(o[1]), 32'd0);
    check({tag, " rdy"}, 32'(o[0]), 32'd1);
  endtask

  task automatic offer(input int m, input logic [7:0] d);
    drive(m, 1'b1, d);
    step();
    drive(m, 1'b0, 8'h00);
  endtask

  // Checks one frame from its first bit; optional stray offer at inj_k,
  // optional reset at rst_k (frame abandoned after that edge).
  task automatic frame(input string tag, input int m,
                       input logic [8:0] exp,
                       input int inj_k, input int rst_k);
    for (int k = 0; k < FLEN; k++) begin
      logic [3:0] o;
      o = obs(m);
      check($sformatf("%s b%0d dout", tag, k), 32'(o[3]), 32'(exp[k]));
      check($sformatf("%s b%0d ov", tag, k), 32'(o[2]), 32'd1);
      check($sformatf("%s b%0d fs", tag, k), 32'(o[1]), 32'(k == 0));
      check($sformatf("%s b%0d rdy", tag, k), 32'(o[0]),
            32'(k == FLEN - 1));
      if (k == inj_k) drive(m, 1'b1, 8'hFF);
      if (k == rst_k) rst = 1'b1;
      step();
      if (k == inj_k) drive(m, 1'b0, 8'h00);
      if (k == rst_k) begin
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    step();
    step();
    rst = 1'b0;
    idle_chk("reset lsb", 0);
    idle_chk("reset msb", 1);

    // A5 LSB first: 1,0,1,0,0,1,0,1 ; parity 0
    offer(0, 8'hA5);
    frame("lsbA5", 0, 9'h0A5, -1, -1);
    idle_chk("lsbA5 end", 0);

    // A5 MSB first: 1,0,1,0,0,1,0,1 ; parity 0
    offer(1, 8'hA5);
    frame("msbA5", 1, 9'h0A5, -1, -1);
    idle_chk("msbA5 end", 1);

    // 01 MSB first: seven 0s then 1 ; parity 1
    offer(1, 8'h01);
    frame("msb01", 1, 9'h180, -1, -1);
    idle_chk("msb01 end", 1);

    // Back-to-back 01 then 80 with par_valid held high
    drive(0, 1'b1, 8'h01);
    step();
    drive(0, 1'b1, 8'h80);
    frame("b2b01", 0, 9'h101, -1, -1);
    drive(0, 1'b0, 8'h00);
    frame("b2b80", 0, 9'h180, -1, -1);
    idle_chk("b2b end", 0);

    // FF offered in cycle 3 of a frame is ignored
    offer(0, 8'hA5);
    frame("ignFF", 0, 9'h0A5, 2, -1);
    idle_chk("ignFF end", 0);
    step();
    idle_chk("ignFF late", 0);

    // Reset during bit 4 of 3C aborts, then 0F serialises
    offer(0, 8'h3C);
    frame("rst3C", 0, 9'h03C, -1, 3);
    idle_chk("rst abort", 0);
    step();
    idle_chk("rst noresume", 0);
    offer(0, 8'h0F);
    frame("post0F", 0, 9'h00F, -1, -1);
    idle_chk("post0F end", 0);

    // Reset wins over a simultaneous accept
    drive(0, 1'b1, 8'hFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    idle_chk("rstprio", 0);
    step();
    idle_chk("rstprio next", 0);

`ifdef PISO_SERIALIZER_PARITY_EN
    // 07: three ones -> parity 1 ; 03: two ones -> parity 0
    offer(0, 8'h07);
    frame("par07", 0, 9'h107, -1, -1);
    idle_chk("par07 end", 0);
    offer(0, 8'h03);
    frame("par03", 0, 9'h003, -1, -1);
    idle_chk("par03 end", 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
